fpu_issue_arbiter: RTL and testbench

//  Shares one fixed-point Fpu (Q15 in 64-bit signed) between NREQ requesters (shader lanes, address gen).

---
 rtl/fpu_issue_arbiter_pkg.sv | 45 ++++
 rtl/fpu_issue_arbiter_rr_arbiter.sv | 41 ++++
 rtl/fpu_issue_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fpu_issue_arbiter_pkg
//   Shared definitions for the FPU issue arbiter: Fpu opcode encodings, the
//   Q15 unit constant, the arbiter FSM state type and the opcode-support check.
//   Opcodes outside the supported set are answered locally with an error
//   response and never reach the Fpu.
// -----------------------------------------------------------------------------
package fpu_issue_arbiter_pkg;

    localparam logic [3:0] FPU_ADD    = 4'b0000;
    localparam logic [3:0] FPU_SUB    = 4'b0001;
    localparam logic [3:0] FPU_MUL    = 4'b0010;
    localparam logic [3:0] FPU_DIV    = 4'b0011;
    localparam logic [3:0] FPU_NEG    = 4'b0100;
    localparam logic [3:0] FPU_ABS    = 4'b0101;
    localparam logic [3:0] FPU_SAT    = 4'b0110;
    localparam logic [3:0] FPU_CMP_LT = 4'b1000;
    localparam logic [3:0] FPU_CMP_EQ = 4'b1001;
    localparam logic [3:0] FPU_CMP_LE = 4'b1010;
    localparam logic [3:0] FPU_MIN    = 4'b1100;
    localparam logic [3:0] FPU_MAX    = 4'b1101;

    // Q15 fixed point carried in 64-bit signed words: 1.0 == 32768
    localparam logic [63:0] Q15_ONE = 64'd32768;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    function automatic logic fpu_op_valid(input logic [3:0] op);
        logic ok;
        case (op)
            FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV,
            FPU_NEG, FPU_ABS, FPU_SAT,
            FPU_CMP_LT, FPU_CMP_EQ, FPU_CMP_LE,
            FPU_MIN, FPU_MAX:  ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fpu_issue_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_issue_arbiter_rr_arbiter
//   Round-robin pick: the first eligible requester at or above rr_ptr_i,
//   wrapping around to 0. Purely combinational; the pointer lives in the FSM.
// Ports
//   eligible_i   NREQ  requesters that may be granted this cycle
//   rr_ptr_i     IDW   highest-priority requester index
//   grant_o      NREQ  one-hot winner (all zero when nothing is eligible)
//   grant_idx_o  IDW   winner index (0 when nothing is eligible)
//   any_o        1     some requester is eligible
// -----------------------------------------------------------------------------
module fpu_issue_arbiter_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            any_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            // modulo keeps the wrap correct for non-power-of-two NREQ
            idx = IDW'((int'(rr_ptr_i) + k) % NREQ);
            if (!any_o && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_issue_arbiter
//   Shares one Q15 fixed-point Fpu between NREQ requesters. Grants one request
//   at a time round-robin, latches its operands, drives the Fpu, waits out the
//   multi-cycle divide using fpu_busy_i and returns the result to the owning
//   requester over a per-lane valid/ready response channel.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | arbitrate; req_ready_o asserted to the round-robin winner
//   ST_EXEC     | latched op on the Fpu; non-divide result captured here
//   ST_DIV_WAIT | divide running; wait for busy to rise then fall
//   ST_RESP     | result presented to owner until its resp_ready_i
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_i         asynchronous active-high reset
//   req_valid_i   NREQ     per-requester operation pending
//   req_op_i      NREQ*4   per-requester opcode, lane i at [4i+3:4i]
//   req_a_i       NREQ*64  per-requester operand A, lane i at [64i+63:64i]
//   req_b_i       NREQ*64  per-requester operand B
//   req_ready_o   NREQ     one-hot grant (IDLE only)
//   resp_valid_o  NREQ     one-hot response valid for the owner
//   resp_ready_i  NREQ     per-requester response accept
//   resp_data_o   64       result (Q15 value or 0/1 for compares)
//   resp_err_o    1        opcode was unsupported
//   fpu_op_o      4        opcode to Fpu
//   fpu_a_o       64       operand A to Fpu
//   fpu_b_o       64       operand B to Fpu
//   fpu_busy_i    1        Fpu divider busy
//   fpu_res_i     64       Fpu result
// -----------------------------------------------------------------------------
module fpu_issue_arbiter
    import fpu_issue_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*4-1:0]    req_op_i,
    input  logic [NREQ*64-1:0]   req_a_i,
    input  logic [NREQ*64-1:0]   req_b_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      resp_valid_o,
    input  logic [NREQ-1:0]      resp_ready_i,
    output logic [63:0]          resp_data_o,
    output logic                 resp_err_o,
    output logic [3:0]           fpu_op_o,
    output logic [63:0]          fpu_a_o,
    output logic [63:0]          fpu_b_o,
    input  logic                 fpu_busy_i,
    input  logic [63:0]          fpu_res_i
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [3:0]      op_q, op_d;
    logic [63:0]     a_q, a_d;
    logic [63:0]     b_q, b_d;
    logic [63:0]     res_q, res_d;
    logic            err_q, err_d;
    logic            seen_busy_q, seen_busy_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [3:0]      op_sel;
    logic [63:0]     a_sel;
    logic [63:0]     b_sel;
    logic            op_ok;

    // A divide cannot be issued while the divider is still busy (including the
    // harmless relaunch that follows every divide capture); other ops can.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid_i[i] &
                          !((req_op_i[i*4 +: 4] == FPU_DIV) & fpu_busy_i);
        end
    end

    fpu_issue_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                op_sel = req_op_i[i*4 +: 4];
                a_sel  = req_a_i[i*64 +: 64];
                b_sel  = req_b_i[i*64 +: 64];
            end
        end
    end

    assign op_ok = fpu_op_valid(op_q);

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            err_q       <= err_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        err_d       = err_q;
        seen_busy_d = seen_busy_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    op_d     = op_sel;
                    a_d      = a_sel;
                    b_d      = b_sel;
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!op_ok) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (op_q == FPU_DIV) begin
                    seen_busy_d = 1'b0;
                    state_d     = ST_DIV_WAIT;
                end else begin
                    res_d   = fpu_res_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_DIV_WAIT: begin
                // busy must be seen high first so a stale low level right after
                // launch is not mistaken for completion
                seen_busy_d = seen_busy_q | fpu_busy_i;
                if (seen_busy_q && !fpu_busy_i) begin
                    res_d   = fpu_res_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        fpu_op_o     = '0;
        fpu_a_o      = '0;
        fpu_b_o      = '0;
        resp_data_o  = res_q;
        resp_err_o   = err_q;

        if (state_q == ST_IDLE) begin
            req_ready_o = grant;
        end
        // unsupported ops never touch the Fpu
        if ((state_q == ST_EXEC || state_q == ST_DIV_WAIT) && op_ok) begin
            fpu_op_o = op_q;
            fpu_a_o  = a_q;
            fpu_b_o  = b_q;
        end
        if (state_q == ST_RESP) begin
            resp_valid_o[id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
module tb_fpu_issue_arbiter;
    import fpu_issue_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ*4-1:0]    req_op_i;
    logic [NREQ*64-1:0]   req_a_i;
    logic [NREQ*64-1:0]   req_b_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ-1:0]      resp_valid_o;
    logic [NREQ-1:0]      resp_ready_i;
    logic [63:0]          resp_data_o;
    logic                 resp_err_o;
    logic [3:0]           fpu_op_o;
    logic [63:0]          fpu_a_o;
    logic [63:0]          fpu_b_o;
    logic                 fpu_busy_i;
    logic [63:0]          fpu_res_i;

    always #5 clk_i = ~clk_i;

    fpu_issue_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .fpu_op_o     (fpu_op_o),
        .fpu_a_o      (fpu_a_o),
        .fpu_b_o      (fpu_b_o),
        .fpu_busy_i   (fpu_busy_i),
        .fpu_res_i    (fpu_res_i)
    );

    // ---------------- small Fpu model: 3-cycle divider, combinational rest
    logic [1:0]         div_cnt;
    logic [63:0]        div_q;
    logic               ext_busy;
    logic signed [63:0] div_calc;
    logic signed [63:0] mul_calc;

    assign div_calc   = (fpu_b_o == 64'd0) ? 64'sd0 : (($signed(fpu_a_o) <<< 15) / $signed(fpu_b_o));
    assign mul_calc   = ($signed(fpu_a_o) * $signed(fpu_b_o)) >>> 15;
    assign fpu_busy_i = (div_cnt != 2'd0) | ext_busy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= 2'd0;
            div_q   <= 64'd0;
        end else if (div_cnt != 2'd0) begin
            div_cnt <= div_cnt - 2'd1;
        end else if (fpu_op_o == FPU_DIV) begin
            div_cnt <= 2'd3;
            div_q   <= div_calc;
        end
    end

    always_comb begin
        case (fpu_op_o)
            FPU_ADD:    fpu_res_i = fpu_a_o + fpu_b_o;
            FPU_SUB:    fpu_res_i = fpu_a_o - fpu_b_o;
            FPU_MUL:    fpu_res_i = mul_calc;
            FPU_DIV:    fpu_res_i = div_q;
            FPU_CMP_LT: fpu_res_i = ($signed(fpu_a_o) < $signed(fpu_b_o)) ? 64'd1 : 64'd0;
            default:    fpu_res_i = 64'h5A5A_5A5A_5A5A_5A5A;
        endcase
    end

    // ---------------- bookkeeping
    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_lane(input int lane, input logic [3:0] op,
                              input logic [63:0] a, input logic [63:0] b);
        req_op_i[lane*4 +: 4]  = op;
        req_a_i[lane*64 +: 64] = a;
        req_b_i[lane*64 +: 64] = b;
        req_valid_i[lane]      = 1'b1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        req_valid_i  = '0;
        resp_ready_i = '0;
        ext_busy     = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    // One request on one lane from issue to response handshake.
    // lat counts cycles from the accept sample to resp_valid; fop_ok tracks that
    // fpu_op matched exp_fop while in flight and was 0 while responding.
    task automatic run_op(input int lane, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] exp_fop,
                          output int waited, output int lat, output logic [63:0] data,
                          output logic err, output bit fop_ok);
        bit got;
        got    = 1'b0;
        waited = 0;
        lat    = 0;
        data   = '1;
        err    = 1'bx;
        fop_ok = 1'b1;
        drive_lane(lane, op, a, b);
        #1;
        while (!got && waited < 50) begin
            if (req_ready_o[lane]) got = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        if (!got) begin
            req_valid_i[lane] = 1'b0;
            return;
        end
        tick();
        req_valid_i[lane] = 1'b0;
        lat = 1;
        while (!resp_valid_o[lane] && lat < 80) begin
            if (fpu_op_o !== exp_fop) fop_ok = 1'b0;
            tick();
            lat++;
        end
        if (resp_valid_o[lane]) begin
            if (fpu_op_o !== 4'b0000) fop_ok = 1'b0;
            data = resp_data_o;
            err  = resp_err_o;
            resp_ready_i[lane] = 1'b1;
            tick();
            resp_ready_i[lane] = 1'b0;
        end
    endtask

    typedef struct {
        int          lane;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  exp_fop;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          waited, lat;
        logic [63:0] data;
        logic        err;
        bit          fop_ok;
        bit          bad;
        int          order[8];
        int          ngrant;
        int          cyc;

        vecs[0] = '{0, 4'b0000, Q15_ONE,      64'd65536,    4'b0000, 64'd98304,  1'b0, 2};
        vecs[1] = '{1, 4'b0001, 64'd65536,    64'd32768,    4'b0001, 64'd32768,  1'b0, 2};
        vecs[2] = '{2, 4'b0010, 64'd65536,    64'd98304,    4'b0010, 64'd196608, 1'b0, 2};
        vecs[3] = '{3, 4'b1000, 64'd1,        64'd2,        4'b1000, 64'd1,      1'b0, 2};
        vecs[4] = '{0, 4'b1111, 64'd7,        64'd9,        4'b0000, 64'd0,      1'b1, 2};
        vecs[5] = '{0, 4'b0000, -64'sd32768,  64'd16384,    4'b0000, -64'sd16384, 1'b0, 2};
        vecs[6] = '{1, 4'b0111, 64'd3,        64'd4,        4'b0000, 64'd0,      1'b1, 2};
        vecs[7] = '{1, 4'b0011, 64'd196608,   64'd65536,    4'b0011, 64'd98304,  1'b0, 6};

        req_op_i = '0;
        req_a_i  = '0;
        req_b_i  = '0;
        rst_i    = 1'b1;
        req_valid_i  = '0;
        resp_ready_i = '0;
        ext_busy     = 1'b0;
        tick();
        tick();
        check("rst_req_ready",  64'(req_ready_o),  64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_resp_data",  resp_data_o,       64'd0);
        check("rst_resp_err",   64'(resp_err_o),   64'd0);
        check("rst_fpu_op",     64'(fpu_op_o),     64'd0);
        rst_i = 1'b0;
        tick();

        // ---------------- table-driven single operations
        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].lane, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp_fop,
                   waited, lat, data, err, fop_ok);
            check($sformatf("v%0d_grant_wait", v), 64'(waited), 64'd0);
            check($sformatf("v%0d_latency", v),    64'(lat),    64'(vecs[v].exp_lat));
            check($sformatf("v%0d_data", v),       data,        vecs[v].exp_data);
            check($sformatf("v%0d_err", v),        64'(err),    64'(vecs[v].exp_err));
            check($sformatf("v%0d_fpu_op", v),     64'(fop_ok), 64'd1);
            check($sformatf("v%0d_resp_drop", v),  64'(resp_valid_o), 64'd0);
        end

        // ---------------- fairness: all lanes busy with MUL
        do_reset();
        for (int i = 0; i < NREQ; i++) drive_lane(i, FPU_MUL, 64'(i + 1) * Q15_ONE, Q15_ONE);
        resp_ready_i = '1;
        #1;
        ngrant = 0;
        cyc    = 0;
        bad    = 1'b0;
        while (ngrant < 8 && cyc < 100) begin
            if (req_ready_o != '0) begin
                if (!$onehot(req_ready_o)) bad = 1'b1;
                for (int i = 0; i < NREQ; i++) if (req_ready_o[i]) order[ngrant] = i;
                ngrant++;
            end
            tick();
            cyc++;
        end
        req_valid_i = '0;
        tick();
        tick();
        tick();
        resp_ready_i = '0;
        check("fair_count",  64'(ngrant), 64'd8);
        check("fair_onehot", 64'(bad),    64'd0);
        for (int g = 0; g < 8; g++) begin
            if (g < ngrant) check($sformatf("fair_order%0d", g), 64'(order[g]), 64'(g % 4));
        end

        // ---------------- divide blocked while the Fpu is busy
        do_reset();
        ext_busy = 1'b1;
        drive_lane(2, FPU_DIV, 64'd196608, 64'd65536);
        drive_lane(3, FPU_ADD, 64'd1, 64'd2);
        #1;
        check("blk_first_grant", 64'(req_ready_o), 64'b1000);
        tick();
        req_valid_i[3]  = 1'b0;
        resp_ready_i[3] = 1'b1;
        bad  = 1'b0;
        data = '1;
        for (int c = 0; c < 8; c++) begin
            if (req_ready_o[2]) bad = 1'b1;
            if (resp_valid_o[3]) data = resp_data_o;
            tick();
        end
        resp_ready_i[3] = 1'b0;
        check("blk_no_div_grant", 64'(bad), 64'd0);
        check("blk_add_data",     data,     64'd3);
        ext_busy = 1'b0;
        #1;
        check("blk_div_grant", 64'(req_ready_o), 64'b0100);
        tick();
        req_valid_i[2] = 1'b0;
        cyc = 0;
        while (!resp_valid_o[2] && cyc < 60) begin
            tick();
            cyc++;
        end
        check("blk_div_resp", 64'(resp_valid_o), 64'b0100);
        check("blk_div_data", resp_data_o,       64'd98304);
        resp_ready_i[2] = 1'b1;
        tick();
        resp_ready_i[2] = 1'b0;

        // ---------------- response backpressure
        do_reset();
        drive_lane(0, FPU_ADD, 64'd100, 64'd200);
        #1;
        check("bp_grant", 64'(req_ready_o), 64'b0001);
        tick();
        req_valid_i[0] = 1'b0;
        cyc = 0;
        while (!resp_valid_o[0] && cyc < 20) begin
            tick();
            cyc++;
        end
        drive_lane(1, FPU_ADD, 64'd5, 64'd6);
        resp_ready_i = 4'b0100;
        #1;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (resp_data_o !== 64'd300 || resp_valid_o !== 4'b0001 ||
                req_ready_o !== 4'b0000 || resp_err_o !== 1'b0) bad = 1'b1;
            tick();
        end
        check("bp_hold_stable", 64'(bad), 64'd0);
        resp_ready_i = 4'b0001;
        tick();
        resp_ready_i = '0;
        check("bp_resp_drop",   64'(resp_valid_o), 64'd0);
        check("bp_next_grant",  64'(req_ready_o),  64'b0010);
        tick();
        req_valid_i[1] = 1'b0;
        cyc = 0;
        while (!resp_valid_o[1] && cyc < 20) begin
            tick();
            cyc++;
        end
        check("bp_next_data", resp_data_o, 64'd11);
        resp_ready_i[1] = 1'b1;
        tick();
        resp_ready_i[1] = 1'b0;

        // ---------------- reset while a divide is in flight
        do_reset();
        drive_lane(0, FPU_DIV, 64'd196608, 64'd65536);
        #1;
        tick();
        req_valid_i[0] = 1'b0;
        tick();
        tick();
        check("rdiv_in_flight", 64'(fpu_op_o), 64'(FPU_DIV));
        rst_i = 1'b1;
        #1;
        check("rdiv_fpu_op",     64'(fpu_op_o),     64'd0);
        check("rdiv_fpu_a",      fpu_a_o,           64'd0);
        check("rdiv_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rdiv_req_ready",  64'(req_ready_o),  64'd0);
        check("rdiv_resp_data",  resp_data_o,       64'd0);
        tick();
        rst_i = 1'b0;
        resp_ready_i = '1;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid_o != '0) bad = 1'b1;
            tick();
        end
        resp_ready_i = '0;
        check("rdiv_no_resp", 64'(bad), 64'd0);
        run_op(2, FPU_ADD, 64'd5, 64'd7, FPU_ADD, waited, lat, data, err, fop_ok);
        check("post_rst_wait", 64'(waited), 64'd0);
        check("post_rst_lat",  64'(lat),    64'd2);
        check("post_rst_data", data,        64'd12);
        check("post_rst_err",  64'(err),    64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
